return_addr_stack: RTL and testbench

- Circular return-address stack (RAS) sitting beside the next-PC logic in the fetch path.
- A branch-with-link pushes its link value (PC+4, same value written to R14); a return (MOV PC,R14 / BX R14) pops it.
- The top entry is driven out as the predicted return target, so fetch can redirect before R14 is read back from the register file.
- The pop side is the consuming end of the link address that the branch-and-link path produces.

---
 rtl/return_addr_stack.sv | 104 ++++++++++
 tb/tb_return_addr_stack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_addr_stack
// Brief    : Circular return-address stack predicting return targets for fetch.
// Revision : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [31:0]      push_addr,
    input  logic             pop,
    output logic [31:0]      top_addr,
    output logic             top_valid,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow,
    output logic             misalign
);

    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_tp;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_misalign;

    logic [31:0]      w_aligned;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_replace;
    logic             w_wr_en;

    assign w_aligned = {push_addr[31:2], 2'b00};
    assign w_top_idx = r_tp - 1'b1;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    // A simultaneous return+call on a non-empty stack rewrites the top in place
    assign w_replace = push && pop && !w_empty;
    assign w_wr_en   = push && !flush;
    assign w_wr_idx  = w_replace ? w_top_idx : r_tp;

    // Entry storage carries no reset; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_aligned;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (flush) begin
            r_tp    <= '0;
            r_count <= '0;
        end else begin
            if (push && (push_addr[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
            if (push && pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                    r_tp        <= r_tp + 1'b1;
                    r_count     <= r_count + 1'b1;
                end
            end else if (push) begin
                r_tp <= r_tp + 1'b1;
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_tp    <= r_tp - 1'b1;
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign top_addr  = w_empty ? 32'd0 : r_mem[w_top_idx];
    assign top_valid = !w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_return_addr_stack
// Brief    : Vector table, corner sequences and random run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             push;
    logic [31:0]      push_addr;
    logic             pop;
    logic [31:0]      top_addr;
    logic             top_valid;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             underflow;
    logic             misalign;

    return_addr_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the live entries, oldest first, plus sticky flags
    logic [31:0] q[$];
    bit          m_ov;
    bit          m_un;
    bit          m_mi;

    typedef struct {
        bit          fl;
        bit          pu;
        bit          po;
        logic [31:0] addr;
        int          cnt;
        logic [31:0] top;
        bit          vld;
        bit          ov;
        bit          un;
        bit          mi;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit f, input bit pu, input bit po, input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        if (f) begin
            q.delete();
        end else begin
            if (pu && (a[1:0] != 2'b00)) m_mi = 1'b1;
            if (pu && po) begin
                if (q.size() > 0) begin
                    q[q.size()-1] = al;
                end else begin
                    m_un = 1'b1;
                    q.push_back(al);
                end
            end else if (pu) begin
                q.push_back(al);
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    m_ov = 1'b1;
                end
            end else if (po) begin
                if (q.size() > 0) void'(q.pop_back());
                else m_un = 1'b1;
            end
        end
    endtask

    task automatic step(input bit f, input bit pu, input bit po, input logic [31:0] a);
        flush     = f;
        push      = pu;
        pop       = po;
        push_addr = a;
        @(posedge clk);
        model_step(f, pu, po, a);
        #1;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] exp_top;
        exp_top = (q.size() > 0) ? q[q.size()-1] : 32'd0;
        check({tag, ".count"},     32'(count),     32'(q.size()));
        check({tag, ".top_addr"},  top_addr,       exp_top);
        check({tag, ".top_valid"}, 32'(top_valid), 32'(q.size() > 0));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ov));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_un));
        check({tag, ".misalign"},  32'(misalign),  32'(m_mi));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #3;
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_mi = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = 32'd0;

        //        fl  pu  po  addr          cnt top           vld ov un mi
        vecs[0]  = '{0, 1, 0, 32'h0000_0100, 1, 32'h0000_0100, 1, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 32'h0000_0204, 2, 32'h0000_0204, 1, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 32'h0000_0308, 3, 32'h0000_0308, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, 32'h0000_0000, 2, 32'h0000_0204, 1, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 32'h0000_0000, 1, 32'h0000_0100, 1, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0};
        vecs[7]  = '{1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0};
        vecs[8]  = '{0, 1, 0, 32'h0000_0400, 1, 32'h0000_0400, 1, 0, 1, 0};
        vecs[9]  = '{0, 1, 0, 32'h0000_0500, 2, 32'h0000_0500, 1, 0, 1, 0};
        vecs[10] = '{0, 1, 1, 32'h0000_0604, 2, 32'h0000_0604, 1, 0, 1, 0};
        vecs[11] = '{0, 0, 1, 32'h0000_0000, 1, 32'h0000_0400, 1, 0, 1, 0};
        vecs[12] = '{0, 1, 0, 32'h0000_0403, 2, 32'h0000_0400, 1, 0, 1, 1};
        vecs[13] = '{1, 1, 0, 32'h0000_0808, 0, 32'h0000_0000, 0, 0, 1, 1};

        #12;
        check("reset.count",     32'(count),     32'd0);
        check("reset.top_valid", 32'(top_valid), 32'd0);
        check("reset.top_addr",  top_addr,       32'd0);
        check("reset.overflow",  32'(overflow),  32'd0);
        check("reset.underflow", 32'(underflow), 32'd0);
        check("reset.misalign",  32'(misalign),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_mi = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].fl, vecs[i].pu, vecs[i].po, vecs[i].addr);
            check($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].cnt));
            check($sformatf("vec%0d.top_addr", i),  top_addr,       vecs[i].top);
            check($sformatf("vec%0d.top_valid", i), 32'(top_valid), 32'(vecs[i].vld));
            check($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].ov));
            check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].un));
            check($sformatf("vec%0d.misalign", i),  32'(misalign),  32'(vecs[i].mi));
        end

        // Asynchronous reset asserted between edges clears the sticky flags at once
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst.underflow", 32'(underflow), 32'd0);
        check("async_rst.misalign",  32'(misalign),  32'd0);
        check("async_rst.count",     32'(count),     32'd0);
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_mi = 1'b0;
        #2;
        reset_n = 1'b1;

        // Nine pushes into an eight-deep stack discard the oldest
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 32'h1000 + 32'(4*i));
        check("ovf.count",    32'(count),    32'd8);
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.top_addr", top_addr,      32'h0000_1020);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf.pop%0d", k), top_addr, 32'h1020 - 32'(4*k));
            step(1'b0, 1'b0, 1'b1, 32'd0);
        end
        check("ovf.empty_valid", 32'(top_valid), 32'd0);
        compare_model("ovf.end");

        // Return+call on an empty stack behaves as a push but flags underflow
        apply_reset();
        step(1'b0, 1'b1, 1'b1, 32'h0000_0700);
        check("pp_empty.count",     32'(count),     32'd1);
        check("pp_empty.top_addr",  top_addr,       32'h0000_0700);
        check("pp_empty.underflow", 32'(underflow), 32'd1);

        apply_reset();
        for (int i = 0; i < 600; i++) begin
            bit          f;
            bit          pu;
            bit          po;
            logic [31:0] a;
            f  = ($urandom_range(0, 49) == 0);
            pu = ($urandom_range(0, 1) == 1);
            po = ($urandom_range(0, 2) == 0);
            a  = $urandom;
            if ($urandom_range(0, 15) != 0) a[1:0] = 2'b00;
            step(f, pu, po, a);
            compare_model($sformatf("rnd%0d", i));
            if (i == 300) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
